// File: rtl/cp0_exc_writer.sv
// MEM-stage exception/interrupt commit unit: sequences EPC/Cause/Status updates
// through the single CP0 write port, then issues a one-cycle flush and redirect.
module cp0_exc_writer #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_pc_i,
  input  logic        in_delay_slot_i,
  input  logic        exc_syscall_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic        cp0_wr_en_o,
  output logic [4:0]  cp0_w_addr_o,
  output logic [31:0] cp0_w_data_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT} state_t;

  state_t      state_q;
  logic        intPend, anyExc, eretOnly, take;
  logic [4:0]  excCode;
  logic [31:0] epcWr_d, causeWr_d, statusWr_d, redirect_d;
  logic [31:0] causeWr_q, statusWr_q, redirect_q;
  logic        wrEn_q, flush_q;
  logic [4:0]  wAddr_q;
  logic [31:0] wData_q, newPc_q;

  // The write values are computed from the inputs at take time and held in
  // registers, so later changes on the CP0 inputs cannot disturb the sequence.
  always_comb begin
    intPend  = inst_valid_i & cp0_status_i[0] & ~cp0_status_i[1]
               & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));
    anyExc   = inst_valid_i & (exc_syscall_i | exc_ri_i | exc_ov_i);
    eretOnly = inst_valid_i & exc_eret_i & ~intPend & ~anyExc;
    take     = (state_q == IDLE) & (intPend | anyExc | eretOnly);

    excCode = 5'd0;
    if (intPend)                              excCode = 5'd0;
    else if (inst_valid_i && exc_syscall_i)   excCode = 5'd8;
    else if (inst_valid_i && exc_ri_i)        excCode = 5'd10;
    else if (inst_valid_i && exc_ov_i)        excCode = 5'd12;

    epcWr_d    = in_delay_slot_i ? inst_pc_i - 32'd4 : inst_pc_i;
    causeWr_d  = (cp0_cause_i & 32'h7FFF_FF83)
                 | {in_delay_slot_i, 24'd0, excCode, 2'd0};
    statusWr_d = eretOnly ? (cp0_status_i & ~32'd2) : (cp0_status_i | 32'd2);
    redirect_d = eretOnly ? cp0_epc_i : EXC_VECTOR;
  end

  // Outputs are registered alongside the state: each state's write/flush is
  // loaded on the edge that enters it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      causeWr_q  <= '0;
      statusWr_q <= '0;
      redirect_q <= '0;
      wrEn_q     <= 1'b0;
      wAddr_q    <= '0;
      wData_q    <= '0;
      flush_q    <= 1'b0;
      newPc_q    <= '0;
    end else begin
      wrEn_q  <= 1'b0;
      wAddr_q <= '0;
      wData_q <= '0;
      flush_q <= 1'b0;
      newPc_q <= '0;
      case (state_q)
        IDLE: begin
          if (take) begin
            causeWr_q  <= causeWr_d;
            statusWr_q <= statusWr_d;
            redirect_q <= redirect_d;
            wrEn_q     <= 1'b1;
            if (eretOnly) begin
              state_q <= W_STATUS;
              wAddr_q <= ADDR_STATUS;
              wData_q <= statusWr_d;
            end else begin
              state_q <= W_EPC;
              wAddr_q <= ADDR_EPC;
              wData_q <= epcWr_d;
            end
          end
        end
        W_EPC: begin
          state_q <= W_CAUSE;
          wrEn_q  <= 1'b1;
          wAddr_q <= ADDR_CAUSE;
          wData_q <= causeWr_q;
        end
        W_CAUSE: begin
          state_q <= W_STATUS;
          wrEn_q  <= 1'b1;
          wAddr_q <= ADDR_STATUS;
          wData_q <= statusWr_q;
        end
        W_STATUS: begin
          state_q <= REDIRECT;
          flush_q <= 1'b1;
          newPc_q <= redirect_q;
        end
        REDIRECT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign cp0_wr_en_o  = wrEn_q;
  assign cp0_w_addr_o = wAddr_q;
  assign cp0_w_data_o = wData_q;
  assign flush_o      = flush_q;
  assign new_pc_o     = newPc_q;
  assign busy_o       = (state_q != IDLE);
  assign stall_o      = take | busy_o;

endmodule

// File: tb/tb_cp0_exc_writer.sv
// Self-checking bench for cp0_exc_writer: directed scenarios with fixed expected
// cycle tables plus randomized transactions against a per-transaction model.
module tb_cp0_exc_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, in_delay_slot_i;
  logic        exc_syscall_i, exc_ri_i, exc_ov_i, exc_eret_i;
  logic [31:0] inst_pc_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        cp0_wr_en_o, stall_o, flush_o, busy_o;
  logic [4:0]  cp0_w_addr_o;
  logic [31:0] cp0_w_data_o, new_pc_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        bd, sys, ri, ov, eret;
    logic [31:0] st, ca, epc;
  } stim_t;

  logic [72:0] expQ[$];

  cp0_exc_writer dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_pc_i(inst_pc_i),
    .in_delay_slot_i(in_delay_slot_i),
    .exc_syscall_i(exc_syscall_i), .exc_ri_i(exc_ri_i),
    .exc_ov_i(exc_ov_i), .exc_eret_i(exc_eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i),
    .cp0_wr_en_o(cp0_wr_en_o), .cp0_w_addr_o(cp0_w_addr_o),
    .cp0_w_data_o(cp0_w_data_o), .stall_o(stall_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [72:0] pk(input logic stall, input logic busy,
                                     input logic flush, input logic [31:0] npc,
                                     input logic en, input logic [4:0] addr,
                                     input logic [31:0] data);
    return {stall, busy, flush, npc, en, addr, data};
  endfunction

  function automatic logic [72:0] obs();
    return {stall_o, busy_o, flush_o, new_pc_o, cp0_wr_en_o, cp0_w_addr_o, cp0_w_data_o};
  endfunction

  function automatic stim_t mk(input logic v, input logic [31:0] pc, input logic bd,
                               input logic sys, input logic ri, input logic ov,
                               input logic eret, input logic [31:0] st,
                               input logic [31:0] ca, input logic [31:0] epc);
    stim_t s;
    s.v = v; s.pc = pc; s.bd = bd; s.sys = sys; s.ri = ri; s.ov = ov;
    s.eret = eret; s.st = st; s.ca = ca; s.epc = epc;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inst_valid_i = 0; inst_pc_i = 0; in_delay_slot_i = 0;
    exc_syscall_i = 0; exc_ri_i = 0; exc_ov_i = 0; exc_eret_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
  endtask

  task automatic drive(input stim_t s);
    inst_valid_i = s.v; inst_pc_i = s.pc; in_delay_slot_i = s.bd;
    exc_syscall_i = s.sys; exc_ri_i = s.ri; exc_ov_i = s.ov; exc_eret_i = s.eret;
    cp0_status_i = s.st; cp0_cause_i = s.ca; cp0_epc_i = s.epc;
  endtask

  task automatic junk();
    inst_valid_i = 1'($urandom); inst_pc_i = $urandom; in_delay_slot_i = 1'($urandom);
    exc_syscall_i = 1'($urandom); exc_ri_i = 1'($urandom); exc_ov_i = 1'($urandom);
    exc_eret_i = 1'($urandom);
    cp0_status_i = $urandom; cp0_cause_i = $urandom; cp0_epc_i = $urandom;
  endtask

  // Reference model: expected per-cycle outputs from the take cycle until idle.
  task automatic model(input stim_t s);
    logic       ip;
    int         code;
    logic [4:0] c5;
    expQ.delete();
    ip = s.v && s.st[0] && !s.st[1] && ((s.ca[15:8] & s.st[15:8]) != 8'd0);
    code = -1;
    if (ip)                code = 0;
    else if (s.v && s.sys) code = 8;
    else if (s.v && s.ri)  code = 10;
    else if (s.v && s.ov)  code = 12;
    c5 = code[4:0];
    if (code >= 0) begin
      expQ.push_back(pk(1, 0, 0, 0, 0, 0, 0));
      expQ.push_back(pk(1, 1, 0, 0, 1, 5'd14, s.bd ? s.pc - 32'd4 : s.pc));
      expQ.push_back(pk(1, 1, 0, 0, 1, 5'd13, {s.bd, s.ca[30:7], c5, s.ca[1:0]}));
      expQ.push_back(pk(1, 1, 0, 0, 1, 5'd12, {s.st[31:2], 1'b1, s.st[0]}));
      expQ.push_back(pk(1, 1, 1, 32'h0000_0020, 0, 0, 0));
      expQ.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    end else if (s.v && s.eret) begin
      expQ.push_back(pk(1, 0, 0, 0, 0, 0, 0));
      expQ.push_back(pk(1, 1, 0, 0, 1, 5'd12, {s.st[31:2], 1'b0, s.st[0]}));
      expQ.push_back(pk(1, 1, 1, s.epc, 0, 0, 0));
      expQ.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    end else begin
      expQ.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset();
    rst = 1;
    quiet();
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (obs() !== 73'd0) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d got=%h exp=%h", i, obs(), 73'd0);
      end
    end
    step();
    rst = 0;
  endtask

  task automatic test_syscall();
    logic [72:0] e[6];
    e[0] = pk(1, 0, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 0, 0, 1, 5'd14, 32'h0000_0100);
    e[2] = pk(1, 1, 0, 0, 1, 5'd13, 32'h0000_0020);
    e[3] = pk(1, 1, 0, 0, 1, 5'd12, 32'h1000_0003);
    e[4] = pk(1, 1, 1, 32'h0000_0020, 0, 0, 0);
    e[5] = pk(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) drive(mk(1, 32'h0000_0100, 0, 1, 0, 0, 0, 32'h1000_0001, 0, 0));
      else quiet();
      @(negedge clk);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("[TB] FAIL syscall T+%0d got=%h exp=%h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_delay_slot_ov();
    logic [72:0] e[6];
    e[0] = pk(1, 0, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 0, 0, 1, 5'd14, 32'h0000_0204);
    e[2] = pk(1, 1, 0, 0, 1, 5'd13, 32'h8000_0030);
    e[3] = pk(1, 1, 0, 0, 1, 5'd12, 32'h0000_0003);
    e[4] = pk(1, 1, 1, 32'h0000_0020, 0, 0, 0);
    e[5] = pk(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) drive(mk(1, 32'h0000_0208, 1, 0, 0, 1, 0, 32'h0000_0001, 0, 0));
      else junk();
      if (i == 5) quiet();
      @(negedge clk);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("[TB] FAIL delay_slot_ov T+%0d got=%h exp=%h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_interrupt();
    logic [72:0] e[6];
    step();
    drive(mk(1, 32'h0000_0300, 0, 0, 0, 0, 0, 32'h0000_8003, 32'h0000_8000, 0));
    @(negedge clk);
    checks++;
    if (obs() !== 73'd0) begin
      errors++;
      $display("[TB] FAIL int_masked_exl got=%h exp=%h", obs(), 73'd0);
    end
    e[0] = pk(1, 0, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 0, 0, 1, 5'd14, 32'h0000_0300);
    e[2] = pk(1, 1, 0, 0, 1, 5'd13, 32'h0000_8000);
    e[3] = pk(1, 1, 0, 0, 1, 5'd12, 32'h0000_8003);
    e[4] = pk(1, 1, 1, 32'h0000_0020, 0, 0, 0);
    e[5] = pk(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) drive(mk(1, 32'h0000_0300, 0, 0, 0, 0, 0, 32'h0000_8001, 32'h0000_8000, 0));
      else quiet();
      @(negedge clk);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("[TB] FAIL int_taken T+%0d got=%h exp=%h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_eret();
    logic [72:0] e[4];
    e[0] = pk(1, 0, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 0, 0, 1, 5'd12, 32'h0000_0001);
    e[2] = pk(1, 1, 1, 32'h0000_0400, 0, 0, 0);
    e[3] = pk(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) drive(mk(1, 32'h0000_0600, 0, 0, 0, 0, 1, 32'h0000_0003, 0, 32'h0000_0400));
      else quiet();
      @(negedge clk);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("[TB] FAIL eret T+%0d got=%h exp=%h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [72:0] e[3];
    e[0] = pk(1, 0, 0, 0, 0, 0, 0);
    e[1] = pk(1, 1, 0, 0, 1, 5'd14, 32'h0000_0100);
    e[2] = pk(1, 1, 0, 0, 1, 5'd13, 32'h0000_0020);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) drive(mk(1, 32'h0000_0100, 0, 1, 0, 0, 0, 32'h1000_0001, 0, 0));
      else quiet();
      if (i == 2) rst = 1;
      @(negedge clk);
      checks++;
      if (obs() !== e[i]) begin
        errors++;
        $display("[TB] FAIL abort T+%0d got=%h exp=%h", i, obs(), e[i]);
      end
    end
    for (int i = 3; i < 7; i++) begin
      step();
      rst = 0;
      @(negedge clk);
      checks++;
      if (obs() !== 73'd0) begin
        errors++;
        $display("[TB] FAIL abort_after_reset T+%0d got=%h exp=%h", i, obs(), 73'd0);
      end
    end
  endtask

  task automatic test_priority();
    stim_t s[2];
    s[0] = mk(1, 32'h0000_0500, 0, 0, 1, 0, 0, 32'h0000_0401, 32'h0000_0400, 0);
    s[1] = mk(1, 32'h0000_0700, 1, 0, 0, 0, 1, 32'h0000_0201, 32'h0000_0203, 32'h0000_0900);
    for (int k = 0; k < 2; k++) begin
      model(s[k]);
      foreach (expQ[i]) begin
        step();
        if (i == 0) drive(s[k]);
        else quiet();
        @(negedge clk);
        checks++;
        if (obs() !== expQ[i]) begin
          errors++;
          $display("[TB] FAIL priority case %0d T+%0d got=%h exp=%h", k, i, obs(), expQ[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int k = 0; k < 60; k++) begin
      s = mk($urandom_range(0, 3) != 0, $urandom, 1'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom, $urandom, $urandom);
      s.st[1] = ($urandom_range(0, 2) == 0);
      model(s);
      foreach (expQ[i]) begin
        step();
        if (i == 0) drive(s);
        else if (i == expQ.size() - 1) quiet();
        else junk();
        @(negedge clk);
        checks++;
        if (obs() !== expQ[i]) begin
          errors++;
          $display("[TB] FAIL random txn %0d T+%0d got=%h exp=%h", k, i, obs(), expQ[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1;
    quiet();
    test_reset();
    test_syscall();
    test_delay_slot_ov();
    test_interrupt();
    test_eret();
    test_abort();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_exc_writer.md
Name: cp0_exc_writer

Overview:
- Exception/interrupt commit unit in the MEM stage of the 5-stage MIPS pipeline.
- Detects exceptions, ERET and pending interrupts on the committing instruction.
- Sequences the required EPC/Cause/Status updates through CP0's single write port, one write per cycle.
- Then issues a one-cycle pipeline flush with the redirect PC. It is the writer side of the CP0 register interface.

Parameters:
- EXC_VECTOR, 32'h0000_0020, exception handler entry address.
- ADDR_STATUS, 5'd12, CP0 Status register number.
- ADDR_CAUSE, 5'd13, CP0 Cause register number.
- ADDR_EPC, 5'd14, CP0 EPC register number.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- inst_valid_i  in  1  MEM-stage instruction valid.
- inst_pc_i  in  32  PC of MEM-stage instruction.
- in_delay_slot_i  in  1  instruction sits in a branch delay slot.
- exc_syscall_i  in  1  SYSCALL.
- exc_ri_i  in  1  reserved instruction.
- exc_ov_i  in  1  arithmetic overflow.
- exc_eret_i  in  1  ERET.
- cp0_status_i  in  32  current Status (IE=bit0, EXL=bit1, IM=bits15:8).
- cp0_cause_i  in  32  current Cause (IP=bits15:8).
- cp0_epc_i  in  32  current EPC.
- cp0_wr_en_o  out  1  CP0 write enable.
- cp0_w_addr_o  out  5  CP0 write address.
- cp0_w_data_o  out  32  CP0 write data.
- stall_o  out  1  freeze IF..MEM while sequencing.
- flush_o  out  1  one-cycle pipeline flush.
- new_pc_o  out  32  redirect target, valid when flush_o=1.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, all latches cleared. All outputs read 0 in IDLE except stall_o (combinational, below). Reset mid-sequence aborts immediately with no further CP0 writes.
- Interrupt pending: int_p = inst_valid_i & status[0] & ~status[1] & |(cause[15:8] & status[15:8]).
- Priority (highest first):
  - int_p: ExcCode 0
  - syscall: ExcCode 8
  - ri: ExcCode 10
  - ov: ExcCode 12
  - eret
- Exception/ERET flags are ignored when inst_valid_i=0.
- take = (state==IDLE) & (int_p | inst_valid_i & (syscall|ri|ov|eret)).
- stall_o = take | (state!=IDLE), combinational.
- On take at cycle T, latch: pc, bd=in_delay_slot_i, code, is_eret, status snapshot, cause snapshot, epc snapshot. Inputs are ignored until the FSM returns to IDLE.
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT.
- Exception path: IDLE -> W_EPC (T+1) -> W_CAUSE (T+2) -> W_STATUS (T+3) -> REDIRECT (T+4) -> IDLE.
  - W_EPC: wr_en=1, addr=ADDR_EPC, data = bd ? pc-32'd4 : pc (modulo 2^32).
  - W_CAUSE: data = {bd, cause_snap[30:7], code[4:0], cause_snap[1:0]}. CP0 applies its own write mask.
  - W_STATUS: data = status_snap with bit1 (EXL) set.
  - REDIRECT: flush_o=1, new_pc_o=EXC_VECTOR, wr_en=0.
- ERET path: IDLE -> W_STATUS (T+1, data = status_snap with bit1 cleared) -> REDIRECT (T+2, new_pc_o=epc_snap) -> IDLE.
- cp0_wr_en_o is high for exactly one cycle per write state. Address and data are 0 when wr_en=0.
- flush_o is high for exactly one cycle per take. No back-to-back take: earliest next take is in the cycle after REDIRECT.
- Simultaneous interrupt and ERET: interrupt wins and ERET is not performed; EPC gets the ERET's PC.
- Interrupt with EXL=1 or IE=0: not taken, instruction proceeds normally.
- Snapshots keep writes consistent even if CP0 inputs change during the sequence.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, busy_o=0.
- SYSCALL: inst_valid_i=1, exc_syscall_i=1, pc=32'h0000_0100, bd=0, status=32'h1000_0001, cause=0 -> T: stall_o=1.
  - T+1: EPC write 32'h0000_0100.
  - T+2: Cause write 32'h0000_0020.
  - T+3: Status write 32'h1000_0003.
  - T+4: flush_o=1, new_pc_o=32'h0000_0020.
  - T+5: busy_o=0.
- Delay-slot overflow: ov=1, pc=32'h0000_0208, bd=1 -> EPC write 32'h0000_0204; Cause data has bit31=1 and [6:2]=12.
- Masked vs. unmasked interrupt: cause[15]=1 with status=32'h0000_8003 (EXL=1) -> no take.
  - Then status=32'h0000_8001 -> take with ExcCode 0.
- ERET: eret=1, status=32'h0000_0003, epc=32'h0000_0400 -> T+1: Status write 32'h0000_0001; T+2: flush_o=1, new_pc_o=32'h0000_0400.
- Abort and priority:
  - rst at T+2 of a SYSCALL sequence -> no Status write, no flush.
  - Separately, int_p and ri together -> ExcCode 0 only.
